// File: rtl/des_key_schedule.sv
// Iterative DES subkey generator: loads a 64-bit key and steps through the
// sixteen round subkeys, forward (encrypt, left rotations) or reverse
// (decrypt, right rotations), one round per advance pulse.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   key_start    one-cycle load pulse, honoured only in IDLE
//   key_in       64-bit DES key, DES bit 1 = key_in[63], parity bits ignored
//   decrypt      mode select sampled with key_start (1 = K16..K1)
//   advance      current round subkey consumed, step to the next round
//   subkey       PC-2 output, DES bit 1 = subkey[47], zero when not ACTIVE
//   subkey_valid high while subkey holds a round key
//   round        current round 1..16, zero when not ACTIVE
//   done         one-cycle pulse after round 16 is consumed
module des_key_schedule (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_start,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        advance,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  output logic [4:0]  round,
  output logic        done
);

  localparam int unsigned KEY_W   = 64;
  localparam int unsigned CD_W    = 56;
  localparam int unsigned HALF_W  = 28;
  localparam int unsigned SUBK_W  = 48;
  localparam int unsigned ROUND_W = 5;

  // PC-1 and PC-2 in DES numbering (bit 1 is the MSB).
  localparam int unsigned PC1 [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2 [SUBK_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
    logic [CD_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(CD_W); i++) begin
      r[6'(int'(CD_W) - 1 - i)] = k[6'(int'(KEY_W) - int'(PC1[i]))];
    end
    return r;
  endfunction

  function automatic logic [SUBK_W-1:0] pc2(input logic [CD_W-1:0] cd);
    logic [SUBK_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(SUBK_W); i++) begin
      r[6'(int'(SUBK_W) - 1 - i)] = cd[6'(int'(CD_W) - int'(PC2[i]))];
    end
    return r;
  endfunction

  // 28-bit rotate by one or two places, left or right.
  function automatic logic [HALF_W-1:0] rot(input logic [HALF_W-1:0] v,
                                             input logic right,
                                             input logic two);
    logic [HALF_W-1:0] r;
    case ({right, two})
      2'b00:   r = {v[26:0], v[27]};
      2'b01:   r = {v[25:0], v[27:26]};
      2'b10:   r = {v[0],    v[27:1]};
      default: r = {v[1:0],  v[27:2]};
    endcase
    return r;
  endfunction

  state_t              state_q;
  logic [HALF_W-1:0]   c_q, d_q;
  logic [ROUND_W-1:0]  round_q;
  logic                mode_q;
  logic                valid_q;
  logic                done_q;

  logic [CD_W-1:0]     cd0;
  logic [ROUND_W-1:0]  sched_idx;
  logic                two_step;
  logic [HALF_W-1:0]   c_nxt, d_nxt;
  logic                unused_parity;

  assign cd0 = pc1(key_in);
  assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                           key_in[24], key_in[16], key_in[8],  key_in[0]};

  // Shift-schedule index for the step out of the current round:
  // S[r+1] going forward, S[17-r] going backward.
  always_comb begin
    sched_idx = '0;
    two_step  = 1'b0;
    c_nxt     = c_q;
    d_nxt     = d_q;
    sched_idx = mode_q ? 5'(5'd17 - round_q) : 5'(round_q + 5'd1);
    two_step  = !((sched_idx == 5'd1) || (sched_idx == 5'd2) ||
                  (sched_idx == 5'd9) || (sched_idx == 5'd16));
    c_nxt     = rot(c_q, mode_q, two_step);
    d_nxt     = rot(d_q, mode_q, two_step);
  end

  // Sequencer and key registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      mode_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (key_start) begin
            // Decrypt starts from C0/D0 directly: 28 total rotations make it C16/D16.
            c_q     <= decrypt ? cd0[55:28] : rot(cd0[55:28], 1'b0, 1'b0);
            d_q     <= decrypt ? cd0[27:0]  : rot(cd0[27:0],  1'b0, 1'b0);
            round_q <= 5'd1;
            mode_q  <= decrypt;
            valid_q <= 1'b1;
            state_q <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (advance) begin
            if (round_q == 5'd16) begin
              round_q <= '0;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              round_q <= 5'(round_q + 5'd1);
              c_q     <= c_nxt;
              d_q     <= d_nxt;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign subkey       = valid_q ? pc2({c_q, d_q}) : '0;
  assign subkey_valid = valid_q;
  assign round        = round_q;
  assign done         = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule using the published subkeys of
// key 133457799BBCDFF1 and the all-ones key (every subkey all ones).
module tb_des_key_schedule;

  logic        clk;
  logic        rst;
  logic        key_start;
  logic [63:0] key_in;
  logic        decrypt;
  logic        advance;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic [4:0]  round;
  logic        done;

  des_key_schedule dut (
    .clk          (clk),
    .rst          (rst),
    .key_start    (key_start),
    .key_in       (key_in),
    .decrypt      (decrypt),
    .advance      (advance),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .round        (round),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] KEY_STD  = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_ONES = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [63:0] PARITY   = 64'h0101010101010101;

  logic [47:0] kenc [1:16];

  typedef struct {
    logic [4:0]  rnd;
    logic [47:0] sk;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] expk(input int kind, input logic dec, input int r);
    if (kind == 1) return 48'hFFFFFFFFFFFF;
    return dec ? kenc[17 - r] : kenc[r];
  endfunction

  task automatic push(input int kind, input logic dec, input int r);
    exp_t e;
    e.rnd = 5'(r);
    e.sk  = expk(kind, dec, r);
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd1);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_subkey"}, 64'(subkey), 64'(e.sk));
    chk({tag, "_round"},  64'(round),  64'(e.rnd));
    chk({tag, "_valid"},  64'(subkey_valid), 64'd1);
    chk({tag, "_done"},   64'(done), 64'd0);
  endtask

  // Full schedule: load, step through 16 rounds with advance asserted at
  // every edge (except optional stall / ignored-start windows), then done.
  task automatic run_sched(input string tag, input logic [63:0] key, input logic dec,
                           input int kind, input logic adv_on_load,
                           input int stall_at, input int ign_at,
                           input logic [63:0] ign_key, input logic ign_dec);
    key_in    = key;
    decrypt   = dec;
    key_start = 1'b1;
    advance   = adv_on_load;
    push(kind, dec, 1);
    tick();
    key_start = 1'b0;
    advance   = 1'b0;
    pop_check({tag, "_load"});
    for (int r = 1; r <= 16; r++) begin
      if (r == stall_at) begin
        repeat (10) tick();
        chk({tag, "_stall_subkey"}, 64'(subkey), 64'(expk(kind, dec, r)));
        chk({tag, "_stall_round"},  64'(round),  64'(r));
      end
      if (r == ign_at) begin
        key_in    = ign_key;
        decrypt   = ign_dec;
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        key_in    = key;
        decrypt   = dec;
        chk({tag, "_ignstart_subkey"}, 64'(subkey), 64'(expk(kind, dec, r)));
        chk({tag, "_ignstart_round"},  64'(round),  64'(r));
      end
      advance = 1'b1;
      if (r < 16) push(kind, dec, r + 1);
      tick();
      advance = 1'b0;
      if (r < 16) begin
        pop_check($sformatf("%s_r%0d", tag, r + 1));
      end else begin
        chk({tag, "_done_pulse"},  64'(done), 64'd1);
        chk({tag, "_done_valid"},  64'(subkey_valid), 64'd0);
        chk({tag, "_done_round"},  64'(round), 64'd0);
        chk({tag, "_done_subkey"}, 64'(subkey), 64'd0);
      end
    end
    tick();
    chk({tag, "_done_low"}, 64'(done), 64'd0);
    chk({tag, "_idle_valid"}, 64'(subkey_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    kenc[1]  = 48'h1B02EFFC7072; kenc[2]  = 48'h79AED9DBC9E5;
    kenc[3]  = 48'h55FC8A42CF99; kenc[4]  = 48'h72ADD6DB351D;
    kenc[5]  = 48'h7CEC07EB53A8; kenc[6]  = 48'h63A53E507B2F;
    kenc[7]  = 48'hEC84B7F618BC; kenc[8]  = 48'hF78A3AC13BFB;
    kenc[9]  = 48'hE0DBEBEDE781; kenc[10] = 48'hB1F347BA464F;
    kenc[11] = 48'h215FD3DED386; kenc[12] = 48'h7571F59467E9;
    kenc[13] = 48'h97C5D1FABA41; kenc[14] = 48'h5F43B7F2E73A;
    kenc[15] = 48'hBF918D3D3F0A; kenc[16] = 48'hCB3D8B0E17F5;

    rst       = 1'b1;
    key_start = 1'b0;
    key_in    = '0;
    decrypt   = 1'b0;
    advance   = 1'b0;
    tick();
    tick();
    chk("reset_subkey", 64'(subkey), 64'd0);
    chk("reset_valid",  64'(subkey_valid), 64'd0);
    chk("reset_round",  64'(round), 64'd0);
    chk("reset_done",   64'(done), 64'd0);
    rst = 1'b0;

    // Advance in IDLE is ignored.
    advance = 1'b1;
    tick();
    advance = 1'b0;
    chk("idle_adv_valid", 64'(subkey_valid), 64'd0);
    chk("idle_adv_round", 64'(round), 64'd0);

    // Encrypt, with a 10-cycle stall in round 5 and an ignored start in round 8.
    run_sched("enc", KEY_STD, 1'b0, 0, 1'b0, 5, 8, KEY_ONES, 1'b1);

    // The key offered mid-schedule now loads after done.
    run_sched("ones", KEY_ONES, 1'b0, 1, 1'b0, 0, 0, '0, 1'b0);

    // Decrypt, with advance coincident with key_start (load only).
    run_sched("dec", KEY_STD, 1'b1, 0, 1'b1, 0, 0, '0, 1'b0);

    // Parity bits flipped: same subkeys.
    run_sched("par", KEY_STD ^ PARITY, 1'b0, 0, 1'b0, 0, 0, '0, 1'b0);

    // Reset at round 10 aborts without a done pulse.
    key_in    = KEY_STD;
    decrypt   = 1'b0;
    key_start = 1'b1;
    tick();
    key_start = 1'b0;
    for (int r = 1; r < 10; r++) begin
      advance = 1'b1;
      tick();
    end
    advance = 1'b0;
    chk("midrst_pre_round",  64'(round), 64'd10);
    chk("midrst_pre_subkey", 64'(subkey), 64'(kenc[10]));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid",  64'(subkey_valid), 64'd0);
    chk("midrst_round",  64'(round), 64'd0);
    chk("midrst_subkey", 64'(subkey), 64'd0);
    chk("midrst_done",   64'(done), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("midrst_nodone_%0d", i), 64'(done), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/des_key_schedule.md
# des_key_schedule

Iterative DES subkey generator that feeds the 48-bit `subkey` input of the DES round datapath. It loads a 64-bit key and produces one round subkey per round step. Encrypt mode produces the subkeys in forward order, K1..K16, using left rotations. Decrypt mode produces them in reverse order, K16..K1, using right rotations, so the same round datapath performs decryption. It is sequenced by the DES controller through a start/advance handshake.

## Interface
- No parameters. The DES constants (PC-1, PC-2 and the shift schedule) are fixed.
- `clk` in, 1: system clock. All logic is rising-edge.
- `rst` in, 1: synchronous, active-high reset. The `n_` prefix is reserved for active-low signals, so this port has no prefix.
- `key_start` in, 1: one-cycle pulse that loads `key_in` and `decrypt`. It is honoured only in IDLE.
- `key_in` in, 64: DES key. DES bit 1 is `key_in[63]`. Parity bits (DES bits 8, 16, …, 64) are ignored.
- `decrypt` in, 1: mode select. 0 selects encrypt (K1→K16); 1 selects decrypt (K16→K1). It is sampled with `key_start`.
- `advance` in, 1: one-cycle pulse from the controller meaning the current round's subkey has been consumed.
- `subkey` out, 48: PC-2 output. DES bit 1 is `subkey[47]`.
- `subkey_valid` out, 1: high while `subkey` holds a valid round key.
- `round` out, 5: current round number, 1..16. It reads 0 when not ACTIVE.
- `done` out, 1: one-cycle pulse after round 16 is consumed.

## Operation
- **Registered state:**
  - `C`, `D`: 28 bits each.
  - `round`: 5 bits.
  - `mode`: 1 bit.
  - FSM with states IDLE, ACTIVE, DONE.
- **Shift schedule:** S[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- **IDLE, `key_start`=1:**
  - PC-1 is applied to `key_in`, giving {C0, D0}.
  - Encrypt: load {C, D} = {rotl(C0,1), rotl(D0,1)}.
  - Decrypt: load {C, D} = {C0, D0}, because the total rotation is 28, so this is C16/D16.
  - Set `round`=1, latch `mode`, go to ACTIVE.
- **IDLE, `key_start`=0:** hold.
- **ACTIVE:**
  - `subkey` = PC-2({C, D}), combinational from the registers.
  - `subkey_valid`=1.
- **ACTIVE, `advance`=1 with `round`<16:**
  - `round` increments to r+1.
  - Encrypt: C and D are each rotated left by S[r+1].
  - Decrypt: C and D are each rotated right by S[17−r].
- **ACTIVE, `advance`=1 with `round`=16:** go to DONE. `round` goes to 0 and `subkey_valid` goes to 0.
- **DONE:** `done`=1 for exactly one cycle, then the FSM returns to IDLE unconditionally.
- **Inputs ignored outside their state:**
  - `key_start` in ACTIVE or DONE is ignored. There is no restart mid-schedule, and the controller must wait for `done`.
  - `advance` in IDLE or DONE is ignored.
- **Simultaneous inputs:** `key_start` and `advance` together in IDLE load the key only. `advance` is ignored.
- **Outputs when not ACTIVE:** `subkey` is forced to 0. It is gated by `subkey_valid`.
- **Rotation widths:** all rotations are within 28 bits, and C and D rotate independently. There are no carries between them.

## Timing
- **Reset:**
  - `rst`=1 at an edge forces IDLE, C=D=0, `round`=0, `mode`=0.
  - Outputs after reset: `subkey`=0, `subkey_valid`=0, `done`=0.
  - Reset mid-schedule aborts immediately. There is no `done` pulse.
- **Load latency:** `key_start` sampled at edge t gives `subkey`=K_first and `round`=1 valid after edge t, i.e. in cycle t+1.
- **Advance latency:** `advance` sampled at edge t gives the next subkey valid in cycle t+1. With `advance` held high every cycle, there is a new subkey every cycle.
- **Schedule length:** minimum 18 cycles from `key_start` to `done`, with 16 ACTIVE cycles.
- **Hold:** `subkey` is stable for as long as `advance`=0. The FSM has no timeout.
- **`done` timing:** asserted in the cycle after the 16th `advance`. `key_start` is accepted again from the cycle after `done`.

## Test plan
- **Encrypt, forward order:** reset, then `key_in`=64'h133457799BBCDFF1 with `decrypt`=0 and a `key_start` pulse → next cycle `subkey`=48'h1B02EFFC7072 with `round`=1. After one `advance` → 48'h79AED9DBC9E5 with `round`=2. After 16 advances total → the last subkey seen was 48'hCB3D8B0E17F5, followed by a single `done` pulse.
- **Decrypt, reverse order:** same key with `decrypt`=1 → first `subkey`=48'hCB3D8B0E17F5 (`round`=1). The sequence of 16 subkeys must equal the encrypt sequence reversed, ending with 48'h1B02EFFC7072.
- **Stalled advance:** hold `advance`=0 for 10 cycles in round 5 → `subkey` and `round` stay constant. After one `advance` → round 6 the next cycle.
- **Ignored start:** a `key_start` with a different key at round 8 → the schedule continues unchanged. After `done`, a new `key_start` loads the new key.
- **Reset mid-run:** assert `rst` at round 10 → next cycle `subkey_valid`=0, `round`=0, `subkey`=0, and no `done` pulse.
- **Parity insensitivity:** `key_in`=64'h133457799BBCDFF1 with all parity bits flipped (XOR 64'h0101010101010101) → the subkey sequence is identical to the encrypt test.
